// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI Stream packet FIFO: write FSM states,
// FIFO mode encoding and the packed payload width.
package axis_fifo_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  localparam int MODE_CUT_THROUGH = 0;
  localparam int MODE_PACKET      = 1;

  // Payload is stored as {tdata, tkeep, tuser, tlast}.
  function automatic int payload_width(input int data_w, input int user_w);
    return data_w + data_w / 8 + user_w + 1;
  endfunction

endpackage

// File: rtl/ram_w.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module ram_w #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_packet_fifo.sv
// Single-clock AXI Stream FIFO with cut-through or store-and-forward packet
// mode, optional drop of overflowing/oversize packets, and fill/drop status.
module axis_packet_fifo
  import axis_fifo_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH   = 512,
  parameter int AXIS_TUSER_WIDTH  = 256,
  parameter int ADDR_WIDTH        = 12,
  parameter int PACKET_MODE       = MODE_PACKET,
  parameter int DROP_WHEN_FULL    = 1,
  parameter int ALMOST_FULL_LEVEL = (2**ADDR_WIDTH) - 4
) (
  input  logic                          aclk,
  input  logic                          reset,
  input  logic [AXIS_DATA_WIDTH-1:0]    write_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  write_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   write_tuser,
  input  logic                          write_tlast,
  input  logic                          write_tvalid,
  output logic                          write_tready,
  output logic [AXIS_DATA_WIDTH-1:0]    read_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  read_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   read_tuser,
  output logic                          read_tlast,
  output logic                          read_tvalid,
  input  logic                          read_tready,
  output logic [ADDR_WIDTH:0]           status_fill,
  output logic                          status_almost_full,
  output logic                          status_drop,
  output logic [31:0]                   status_drop_count
);

  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam int PTR_W     = ADDR_WIDTH + 1;
  localparam int PAYLOAD_W = payload_width(AXIS_DATA_WIDTH, AXIS_TUSER_WIDTH);
  localparam bit PKT_MODE  = (PACKET_MODE == MODE_PACKET);
  localparam bit DROP_EN   = PKT_MODE && (DROP_WHEN_FULL != 0);
  localparam logic [PTR_W-1:0] PKT_LIMIT = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] AF_LEVEL  = PTR_W'(ALMOST_FULL_LEVEL);

  wr_state_e          state_q;
  wr_state_e          state_d;
  logic [PTR_W-1:0]   write_cur;
  logic [PTR_W-1:0]   write_commit;
  logic [PTR_W-1:0]   read_ptr;
  logic [PTR_W-1:0]   next_read_ptr;
  logic [PTR_W-1:0]   pkt_len;
  logic               full;
  logic               empty;
  logic               wr_acc;
  logic               wr_en;
  logic               drop_now;
  logic               drop_pulse;
  logic               rd_fire;
  logic [PAYLOAD_W-1:0] wr_payload;
  logic [PAYLOAD_W-1:0] ram_q_p1;
  logic [PAYLOAD_W-1:0] byp_data_p1;
  logic [PAYLOAD_W-1:0] rd_payload_p1;
  logic                 byp_vld_p1;

  assign full    = (write_cur[ADDR_WIDTH-1:0] == read_ptr[ADDR_WIDTH-1:0]) &&
                   (write_cur[ADDR_WIDTH] != read_ptr[ADDR_WIDTH]);
  assign empty   = (read_ptr == write_commit);
  assign pkt_len = write_cur - write_commit;

  // While a droppable packet is in flight the slave is always ready, so an
  // overflowing beat can be swallowed instead of stalling the producer.
  always_comb begin
    write_tready = 1'b0;
    if (!reset) begin
      if (state_q == WR_DROP)                  write_tready = 1'b1;
      else if (DROP_EN && state_q == WR_PKT)   write_tready = 1'b1;
      else                                     write_tready = ~full;
    end
  end

  assign wr_acc = write_tvalid && write_tready;

  always_comb begin
    drop_now = 1'b0;
    if (DROP_EN && wr_acc && state_q != WR_DROP)
      drop_now = (state_q == WR_PKT && full) ||
                 (!write_tlast && pkt_len == PKT_LIMIT);
  end

  assign wr_en      = wr_acc && (state_q != WR_DROP) && !drop_now;
  assign drop_pulse = wr_acc && write_tlast && (state_q == WR_DROP || drop_now);

  always_comb begin
    state_d = state_q;
    if (wr_acc) begin
      if (write_tlast)              state_d = WR_IDLE;
      else if (drop_now)            state_d = WR_DROP;
      else if (state_q == WR_IDLE)  state_d = WR_PKT;
    end
  end

  assign read_tvalid   = ~empty;
  assign rd_fire       = read_tvalid && read_tready;
  assign next_read_ptr = read_ptr + PTR_W'(rd_fire);

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q           <= WR_IDLE;
      write_cur         <= '0;
      write_commit      <= '0;
      read_ptr          <= '0;
      status_drop       <= 1'b0;
      status_drop_count <= '0;
      byp_vld_p1        <= 1'b0;
    end else begin
      state_q  <= state_d;
      read_ptr <= next_read_ptr;
      if (drop_now)   write_cur <= write_commit;
      else if (wr_en) write_cur <= write_cur + PTR_W'(1);
      if (wr_en && (write_tlast || !PKT_MODE))
        write_commit <= write_cur + PTR_W'(1);
      status_drop <= drop_pulse;
      if (drop_pulse && status_drop_count != 32'hFFFF_FFFF)
        status_drop_count <= status_drop_count + 32'd1;
      byp_vld_p1 <= wr_en &&
                    (write_cur[ADDR_WIDTH-1:0] == next_read_ptr[ADDR_WIDTH-1:0]);
    end
  end

  // p1: RAM read of next_read_ptr; a same-cycle write to that slot is
  // forwarded from the bypass register since the RAM returns old contents.
  assign wr_payload = {write_tdata, write_tkeep, write_tuser, write_tlast};

  always_ff @(posedge aclk) begin
    byp_data_p1 <= wr_payload;
  end

  ram_w #(
    .WIDTH  (PAYLOAD_W),
    .ADDR_W (ADDR_WIDTH)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (wr_en),
    .wr_addr (write_cur[ADDR_WIDTH-1:0]),
    .wr_data (wr_payload),
    .rd_addr (next_read_ptr[ADDR_WIDTH-1:0]),
    .rd_data (ram_q_p1)
  );

  assign rd_payload_p1 = byp_vld_p1 ? byp_data_p1 : ram_q_p1;
  assign {read_tdata, read_tkeep, read_tuser, read_tlast} = rd_payload_p1;

  assign status_fill        = write_cur - read_ptr;
  assign status_almost_full = (status_fill >= AF_LEVEL);

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: cut-through, packet/drop and packet/backpressure
// instances at DEPTH 16, with a per-instance expected-beat queue.
module tb_axis_packet_fifo;

  typedef logic [22:0] beat_t;

  logic aclk = 1'b0;
  logic reset = 1'b1;
  always #5 aclk = ~aclk;

  logic [15:0] w_data = '0;
  logic [1:0]  w_keep = 2'b11;
  logic [3:0]  w_user = '0;
  logic        w_last = 1'b0;
  logic a_vld = 1'b0, b_vld = 1'b0, c_vld = 1'b0;
  logic a_rdy = 1'b0, b_rdy = 1'b0, c_rdy = 1'b0;

  logic a_wready, b_wready, c_wready;
  logic [15:0] a_tdata, b_tdata, c_tdata;
  logic [1:0]  a_tkeep, b_tkeep, c_tkeep;
  logic [3:0]  a_tuser, b_tuser, c_tuser;
  logic a_tlast, b_tlast, c_tlast;
  logic a_tvalid, b_tvalid, c_tvalid;
  logic [4:0] a_fill, b_fill, c_fill;
  logic a_af, b_af, c_af;
  logic a_drop, b_drop, c_drop;
  logic [31:0] a_cnt, b_cnt, c_cnt;

  beat_t a_out, b_out, c_out;
  assign a_out = {a_tdata, a_tkeep, a_tuser, a_tlast};
  assign b_out = {b_tdata, b_tkeep, b_tuser, b_tlast};
  assign c_out = {c_tdata, c_tkeep, c_tuser, c_tlast};

  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];
  int n_tests = 0;
  int n_fail  = 0;

  axis_packet_fifo #(.AXIS_DATA_WIDTH(16), .AXIS_TUSER_WIDTH(4), .ADDR_WIDTH(4),
                     .PACKET_MODE(0), .DROP_WHEN_FULL(0)) u_a (
    .aclk(aclk), .reset(reset),
    .write_tdata(w_data), .write_tkeep(w_keep), .write_tuser(w_user), .write_tlast(w_last),
    .write_tvalid(a_vld), .write_tready(a_wready),
    .read_tdata(a_tdata), .read_tkeep(a_tkeep), .read_tuser(a_tuser), .read_tlast(a_tlast),
    .read_tvalid(a_tvalid), .read_tready(a_rdy),
    .status_fill(a_fill), .status_almost_full(a_af), .status_drop(a_drop),
    .status_drop_count(a_cnt));

  axis_packet_fifo #(.AXIS_DATA_WIDTH(16), .AXIS_TUSER_WIDTH(4), .ADDR_WIDTH(4),
                     .PACKET_MODE(1), .DROP_WHEN_FULL(1)) u_b (
    .aclk(aclk), .reset(reset),
    .write_tdata(w_data), .write_tkeep(w_keep), .write_tuser(w_user), .write_tlast(w_last),
    .write_tvalid(b_vld), .write_tready(b_wready),
    .read_tdata(b_tdata), .read_tkeep(b_tkeep), .read_tuser(b_tuser), .read_tlast(b_tlast),
    .read_tvalid(b_tvalid), .read_tready(b_rdy),
    .status_fill(b_fill), .status_almost_full(b_af), .status_drop(b_drop),
    .status_drop_count(b_cnt));

  axis_packet_fifo #(.AXIS_DATA_WIDTH(16), .AXIS_TUSER_WIDTH(4), .ADDR_WIDTH(4),
                     .PACKET_MODE(1), .DROP_WHEN_FULL(0)) u_c (
    .aclk(aclk), .reset(reset),
    .write_tdata(w_data), .write_tkeep(w_keep), .write_tuser(w_user), .write_tlast(w_last),
    .write_tvalid(c_vld), .write_tready(c_wready),
    .read_tdata(c_tdata), .read_tkeep(c_tkeep), .read_tuser(c_tuser), .read_tlast(c_tlast),
    .read_tvalid(c_tvalid), .read_tready(c_rdy),
    .status_fill(c_fill), .status_almost_full(c_af), .status_drop(c_drop),
    .status_drop_count(c_cnt));

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_beat(input logic [15:0] d, input logic last);
    w_data = d;
    w_user = d[3:0];
    w_last = last;
  endtask

  function automatic beat_t cur_beat();
    return {w_data, w_keep, w_user, w_last};
  endfunction

  task automatic test_reset();
    logic [40:0] want;
    want = {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0};
    reset = 1'b1;
    repeat (3) step();
    @(negedge aclk);
    n_tests++;
    if ({a_wready, b_wready, c_wready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_tready: got %b want 000", {a_wready, b_wready, c_wready});
    end
    step();
    reset = 1'b0;
    @(negedge aclk);
    n_tests++;
    if ({a_wready, a_tvalid, a_fill, a_af, a_drop, a_cnt} !== want) begin
      n_fail++;
      $display("FAIL reset_state_a: got %h want %h", {a_wready, a_tvalid, a_fill, a_af, a_drop, a_cnt}, want);
    end
    n_tests++;
    if ({b_wready, b_tvalid, b_fill, b_af, b_drop, b_cnt} !== want) begin
      n_fail++;
      $display("FAIL reset_state_b: got %h want %h", {b_wready, b_tvalid, b_fill, b_af, b_drop, b_cnt}, want);
    end
    n_tests++;
    if ({c_wready, c_tvalid, c_fill, c_af, c_drop, c_cnt} !== want) begin
      n_fail++;
      $display("FAIL reset_state_c: got %h want %h", {c_wready, c_tvalid, c_fill, c_af, c_drop, c_cnt}, want);
    end
    step();
  endtask

  task automatic test_cut_through();
    beat_t exp;
    a_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_beat(16'h1000 + 16'(i), i == 4);
      a_vld = 1'b1;
      @(negedge aclk);
      if (i == 0) begin
        n_tests++;
        if (a_tvalid !== 1'b0) begin n_fail++; $display("FAIL ct_valid_early: got %b want 0", a_tvalid); end
      end
      if (i == 1) begin
        n_tests++;
        if ({a_tvalid, a_out} !== {1'b1, qa[0]}) begin
          n_fail++; $display("FAIL ct_first_beat: got %h want %h", {a_tvalid, a_out}, {1'b1, qa[0]});
        end
      end
      if (i == 3) begin
        n_tests++;
        if (a_fill !== 5'd3) begin n_fail++; $display("FAIL ct_fill3: got %0d want 3", a_fill); end
      end
      qa.push_back(cur_beat());
      step();
    end
    a_vld = 1'b0;
    a_rdy = 1'b1;
    for (int k = 0; k < 40 && qa.size() > 0; k++) begin
      @(negedge aclk);
      if (a_tvalid) begin
        exp = qa.pop_front();
        n_tests++;
        if (a_out !== exp) begin n_fail++; $display("FAIL ct_read: got %h want %h", a_out, exp); end
      end
      step();
    end
    a_rdy = 1'b0;
    n_tests++;
    if (qa.size() != 0) begin n_fail++; $display("FAIL ct_drain: got %0d left want 0", qa.size()); end
  endtask

  task automatic test_store_forward();
    beat_t exp;
    b_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_beat(16'h2000 + 16'(i), i == 4);
      b_vld = 1'b1;
      @(negedge aclk);
      n_tests++;
      if (b_tvalid !== 1'b0) begin n_fail++; $display("FAIL sf_hold_%0d: got %b want 0", i, b_tvalid); end
      qb.push_back(cur_beat());
      step();
    end
    b_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      exp = qb.pop_front();
      n_tests++;
      if ({b_tvalid, b_out} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL sf_beat_%0d: got %h want %h", k, {b_tvalid, b_out}, {1'b1, exp});
      end
      step();
    end
    @(negedge aclk);
    n_tests++;
    if (b_tvalid !== 1'b0) begin n_fail++; $display("FAIL sf_empty: got %b want 0", b_tvalid); end
    b_rdy = 1'b0;
    step();
  endtask

  task automatic test_overflow_drop();
    beat_t exp;
    int pulses, notready;
    pulses = 0;
    notready = 0;
    b_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_beat(16'h3000 + 16'(i), i == 9);
      b_vld = 1'b1;
      @(negedge aclk);
      if (!b_wready) notready++;
      qb.push_back(cur_beat());
      step();
    end
    for (int i = 0; i < 9; i++) begin
      set_beat(16'h4000 + 16'(i), i == 8);
      @(negedge aclk);
      if (!b_wready) notready++;
      if (b_drop) pulses++;
      step();
    end
    b_vld = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      if (b_drop) pulses++;
      step();
    end
    @(negedge aclk);
    n_tests++;
    if (notready != 0) begin n_fail++; $display("FAIL ovf_ready: got %0d stalls want 0", notready); end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d want 1", pulses); end
    n_tests++;
    if (b_cnt !== 32'd1) begin n_fail++; $display("FAIL ovf_count: got %0d want 1", b_cnt); end
    n_tests++;
    if (b_fill !== 5'd10) begin n_fail++; $display("FAIL ovf_fill: got %0d want 10", b_fill); end
    step();
    b_rdy = 1'b1;
    for (int k = 0; k < 40 && qb.size() > 0; k++) begin
      @(negedge aclk);
      if (b_tvalid) begin
        exp = qb.pop_front();
        n_tests++;
        if (b_out !== exp) begin n_fail++; $display("FAIL ovf_read: got %h want %h", b_out, exp); end
      end
      step();
    end
    @(negedge aclk);
    n_tests++;
    if ({qb.size() == 0, b_tvalid} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_drain: got %0d left valid %b want 0 left valid 0", qb.size(), b_tvalid);
    end
    b_rdy = 1'b0;
    step();
  endtask

  task automatic test_oversize();
    int pulses, notready, seen;
    pulses = 0;
    notready = 0;
    seen = 0;
    b_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_beat(16'h5000 + 16'(i), i == 19);
      b_vld = 1'b1;
      @(negedge aclk);
      if (!b_wready) notready++;
      if (b_tvalid) seen++;
      if (b_drop) pulses++;
      step();
    end
    b_vld = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      if (b_tvalid) seen++;
      if (b_drop) pulses++;
      step();
    end
    @(negedge aclk);
    n_tests++;
    if (notready != 0) begin n_fail++; $display("FAIL big_ready: got %0d stalls want 0", notready); end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL big_visible: got %0d valid cycles want 0", seen); end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL big_pulse: got %0d want 1", pulses); end
    n_tests++;
    if (b_cnt !== 32'd2) begin n_fail++; $display("FAIL big_count: got %0d want 2", b_cnt); end
    n_tests++;
    if (b_fill !== 5'd0) begin n_fail++; $display("FAIL big_fill: got %0d want 0", b_fill); end
    b_rdy = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    beat_t exp;
    logic [6:0] want;
    c_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_beat(16'h7000 + 16'(i), i == 15);
      c_vld = 1'b1;
      @(negedge aclk);
      want = {1'b1, 5'(i), i >= 12};
      n_tests++;
      if ({c_wready, c_fill, c_af} !== want) begin
        n_fail++; $display("FAIL bp_fill_%0d: got %h want %h", i, {c_wready, c_fill, c_af}, want);
      end
      qc.push_back(cur_beat());
      step();
    end
    set_beat(16'h7100, 1'b1);
    c_rdy = 1'b1;
    @(negedge aclk);
    n_tests++;
    if ({c_wready, c_fill, c_af, c_tvalid} !== {1'b0, 5'd16, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL bp_full: got %h want %h", {c_wready, c_fill, c_af, c_tvalid}, {1'b0, 5'd16, 1'b1, 1'b1});
    end
    exp = qc.pop_front();
    n_tests++;
    if (c_out !== exp) begin n_fail++; $display("FAIL bp_read_full: got %h want %h", c_out, exp); end
    step();
    c_rdy = 1'b0;
    @(negedge aclk);
    n_tests++;
    if (c_wready !== 1'b1) begin n_fail++; $display("FAIL bp_freed: got %b want 1", c_wready); end
    qc.push_back(cur_beat());
    step();
    c_vld = 1'b0;
    @(negedge aclk);
    n_tests++;
    if (c_fill !== 5'd16) begin n_fail++; $display("FAIL bp_refill: got %0d want 16", c_fill); end
    step();
    c_rdy = 1'b1;
    for (int k = 0; k < 60 && qc.size() > 0; k++) begin
      @(negedge aclk);
      if (c_tvalid) begin
        exp = qc.pop_front();
        n_tests++;
        if (c_out !== exp) begin n_fail++; $display("FAIL bp_read: got %h want %h", c_out, exp); end
      end
      step();
    end
    c_rdy = 1'b0;
    n_tests++;
    if (qc.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d left want 0", qc.size()); end
  endtask

  task automatic test_wrap_reset();
    beat_t exp;
    int sent, got;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 600 && (sent < 40 || qb.size() > 0); cyc++) begin
      b_vld = (sent < 40);
      set_beat(16'h8000 + 16'(sent), 1'b1);
      b_rdy = 1'($urandom_range(0, 1));
      @(negedge aclk);
      if (b_tvalid && b_rdy) begin
        got++;
        n_tests++;
        if (qb.size() == 0) begin
          n_fail++; $display("FAIL wrap_extra: got %h want none", b_out);
        end else begin
          exp = qb.pop_front();
          if (b_out !== exp) begin n_fail++; $display("FAIL wrap_order: got %h want %h", b_out, exp); end
        end
      end
      if (b_vld && b_wready) begin
        qb.push_back(cur_beat());
        sent++;
      end
      step();
    end
    b_vld = 1'b0;
    b_rdy = 1'b0;
    n_tests++;
    if (got != 40) begin n_fail++; $display("FAIL wrap_count: got %0d want 40", got); end
    for (int i = 0; i < 2; i++) begin
      set_beat(16'h9000 + 16'(i), 1'b1);
      b_vld = 1'b1;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set_beat(16'h9100 + 16'(i), 1'b0);
      step();
    end
    b_vld = 1'b0;
    @(negedge aclk);
    n_tests++;
    if ({b_tvalid, b_fill} !== {1'b1, 5'd5}) begin
      n_fail++; $display("FAIL pre_reset: got %h want %h", {b_tvalid, b_fill}, {1'b1, 5'd5});
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge aclk);
    n_tests++;
    if ({b_wready, b_tvalid, b_fill, b_af, b_drop, b_cnt} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want %h", {b_wready, b_tvalid, b_fill, b_af, b_drop, b_cnt},
               {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0});
    end
    qb.delete();
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cut_through();
    test_store_forward();
    test_overflow_drop();
    test_oversize();
    test_backpressure();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
